// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing-mode type and default geometry for the I2S transmitter.
package i2s_pkg;

  typedef enum logic {
    I2S_MODE_PHILIPS = 1'b0,
    I2S_MODE_LJ      = 1'b1
  } i2s_mode_e;

  localparam int I2S_DATA_W = 16;
  localparam int I2S_SLOT_W = 16;
  localparam int I2S_DIV    = 16;

endpackage

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: divides sclk into bclk (2*DIV sclk per period) and flags each high-to-low bclk edge.
module i2s_clk_div #(
  parameter int DIV = 16
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  // fall is asserted in the cycle whose closing edge drives bclk low, so the
  // framing registers update on the very same edge as bclk itself.
  assign wrap = en && (cnt_q == CNT_MAX);
  assign fall = wrap && bclk_q;
  assign bclk = bclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!en) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S / left-justified serial transmitter with a one-pair holding buffer.
// Define I2S_TX_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int DIV    = I2S_DIV
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              sd,
  output logic              underflow
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PW      = $clog2(FRAME_W);
  localparam logic [PW-1:0] P_LAST = PW'(FRAME_W - 1);

  logic               fall, frameStart, accept;
  logic [PW-1:0]      p_q, p_d, pLead;
  logic [FRAME_W-1:0] shift_q, shift_d, loadWord;
  logic [SLOT_W-1:0]  slotL, slotR;
  logic [DATA_W-1:0]  bufL_q, bufL_d, bufR_q, bufR_d;
  logic               bufFull_q, bufFull_d;
  i2s_mode_e          mode_q, mode_d, modeNow;
  logic               lrclk_q, lrclk_d, sd_q, sd_d, underflow_q, underflow_d;

  i2s_clk_div #(.DIV(DIV)) u_clk_div (
    .sclk  (sclk),
    .rst_n (rst_n),
    .en    (en),
    .bclk  (bclk),
    .fall  (fall)
  );

  assign frameStart = fall && (p_q == P_LAST);
  assign accept     = s_valid && !bufFull_q;
  assign s_ready    = !bufFull_q;
  assign slotL      = SLOT_W'(bufL_q) << (SLOT_W - DATA_W);
  assign slotR      = SLOT_W'(bufR_q) << (SLOT_W - DATA_W);
  assign loadWord   = bufFull_q ? {slotL, slotR} : '0;
  assign modeNow    = frameStart ? i2s_mode_e'(mode) : mode_q;

  // The shifter emits stream bit p on the fall that moves the position to p;
  // in I2S mode lrclk looks one bit ahead so it switches before the MSB.
  always_comb begin
    p_d         = p_q;
    pLead       = '0;
    shift_d     = shift_q;
    lrclk_d     = lrclk_q;
    sd_d        = sd_q;
    mode_d      = mode_q;
    underflow_d = 1'b0;
    bufFull_d   = bufFull_q;
    bufL_d      = bufL_q;
    bufR_d      = bufR_q;
    if (!en) begin
      p_d     = P_LAST;
      shift_d = '0;
      lrclk_d = 1'b0;
      sd_d    = 1'b0;
    end else if (fall) begin
      p_d   = frameStart ? '0 : p_q + PW'(1);
      pLead = (p_d == P_LAST) ? '0 : p_d + PW'(1);
      if (frameStart) begin
        sd_d        = loadWord[FRAME_W-1];
        shift_d     = loadWord << 1;
        mode_d      = modeNow;
        bufFull_d   = 1'b0;
        underflow_d = !bufFull_q;
      end else begin
        sd_d    = shift_q[FRAME_W-1];
        shift_d = shift_q << 1;
      end
      if (modeNow == I2S_MODE_LJ) lrclk_d = (int'(p_d) >= SLOT_W);
      else                        lrclk_d = (int'(pLead) >= SLOT_W);
    end
    // Accept only happens when empty, so a same-cycle frame start still underflows.
    if (accept) begin
      bufFull_d = 1'b1;
      bufL_d    = s_left;
      bufR_d    = s_right;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= P_LAST;
      shift_q     <= '0;
      lrclk_q     <= 1'b0;
      sd_q        <= 1'b0;
      mode_q      <= I2S_MODE_PHILIPS;
      underflow_q <= 1'b0;
      bufFull_q   <= 1'b0;
      bufL_q      <= '0;
      bufR_q      <= '0;
    end else begin
      p_q         <= p_d;
      shift_q     <= shift_d;
      lrclk_q     <= lrclk_d;
      sd_q        <= sd_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
      bufFull_q   <= bufFull_d;
      bufL_q      <= bufL_d;
      bufR_q      <= bufR_d;
    end
  end

  assign lrclk     = lrclk_q;
  assign sd        = sd_q;
  assign underflow = underflow_q;

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] ufCnt_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ufCnt_q <= '0;
    end else if (underflow_d && (ufCnt_q != 16'hFFFF)) begin
      ufCnt_q <= ufCnt_q + 16'd1;
    end
  end

  assign underflow_cnt = ufCnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized self-checking bench for i2s_tx against a per-bit framing model.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DIV = 2;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en16 = 1'b0, mode16 = 1'b0, valid16 = 1'b0;
  logic [15:0] left16 = '0, right16 = '0;
  logic        ready16, bclk16, lrclk16, sd16, uf16;
  logic        en24 = 1'b0, mode24 = 1'b0, valid24 = 1'b0;
  logic [23:0] left24 = '0, right24 = '0;
  logic        ready24, bclk24, lrclk24, sd24, uf24;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] ufCnt16, ufCnt24;
`endif
  logic [15:0] nextL, nextR;
  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  i2s_tx #(.DATA_W(16), .SLOT_W(16), .DIV(DIV)) dut (
    .sclk(sclk), .rst_n(rst_n), .en(en16), .mode(mode16), .s_valid(valid16),
    .s_ready(ready16), .s_left(left16), .s_right(right16), .bclk(bclk16),
    .lrclk(lrclk16), .sd(sd16), .underflow(uf16)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    , .underflow_cnt(ufCnt16)
`endif
  );

  i2s_tx #(.DATA_W(24), .SLOT_W(32), .DIV(DIV)) dutWide (
    .sclk(sclk), .rst_n(rst_n), .en(en24), .mode(mode24), .s_valid(valid24),
    .s_ready(ready24), .s_left(left24), .s_right(right24), .bclk(bclk24),
    .lrclk(lrclk24), .sd(sd24), .underflow(uf24)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    , .underflow_cnt(ufCnt24)
`endif
  );

  // Stream bit p of a frame: left slot then right slot, MSB first, zero padded.
  function automatic logic modelSd(bit have, logic [31:0] l, logic [31:0] r, int dw, int sw, int p);
    logic [31:0] samp;
    int q;
    if (!have) return 1'b0;
    samp = (p < sw) ? l : r;
    q = p % sw;
    if (q >= dw) return 1'b0;
    return samp[dw-1-q];
  endfunction

  function automatic logic modelLr(bit lj, int sw, int p);
    if (lj) return p >= sw;
    return ((p + 1) % (2 * sw)) >= sw;
  endfunction

  // Starts one sclk after a frame-start edge and ends one sclk after the next one.
  task automatic captureFrame(input bit wide, input bit have, input logic [31:0] l,
                              input logic [31:0] r, input bit lj, input string name);
    int sw, dw;
    logic expSd, expLr, obsSd, obsLr, obsB, obsU;
    sw = wide ? 32 : 16;
    dw = wide ? 24 : 16;
    for (int p = 0; p < 2 * sw; p++) begin
      @(posedge sclk); #1;
      if (p == 0) begin
        obsU = wide ? uf24 : uf16;
        checks++;
        if (obsU !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s uf_pulse_width: got %b, want 0", name, obsU);
        end
      end
      repeat (DIV - 1) @(posedge sclk);
      #1;
      obsSd = wide ? sd24 : sd16;
      obsLr = wide ? lrclk24 : lrclk16;
      obsB  = wide ? bclk24 : bclk16;
      obsU  = wide ? uf24 : uf16;
      expSd = modelSd(have, l, r, dw, sw, p);
      expLr = modelLr(lj, sw, p);
      checks++;
      if (obsB !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s bclk_rise p=%0d: got %b, want 1", name, p, obsB);
      end
      checks++;
      if (obsSd !== expSd) begin
        errors++;
        $display("[TB] FAIL %s sd p=%0d: got %b, want %b", name, p, obsSd, expSd);
      end
      checks++;
      if (obsLr !== expLr) begin
        errors++;
        $display("[TB] FAIL %s lrclk p=%0d: got %b, want %b", name, p, obsLr, expLr);
      end
      checks++;
      if (obsU !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s uf_midframe p=%0d: got %b, want 0", name, p, obsU);
      end
      repeat (DIV) @(posedge sclk);
      #1;
    end
  endtask

  task automatic pushPair16(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    left16 = l;
    right16 = r;
    valid16 = 1'b1;
    while (!ready16 && n < 1000) begin
      @(posedge sclk); #1;
      n++;
    end
    checks++;
    if (!ready16) begin
      errors++;
      $display("[TB] FAIL push_timeout: got ready=%b, want 1", ready16);
    end
    @(posedge sclk); #1;
    valid16 = 1'b0;
  endtask

  task automatic checkUf16(input logic expU, input int expCnt, input string name);
    checks++;
    if (uf16 !== expU) begin
      errors++;
      $display("[TB] FAIL %s underflow: got %b, want %b", name, uf16, expU);
    end
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    if (expCnt >= 0) begin
      checks++;
      if (ufCnt16 !== 16'(expCnt)) begin
        errors++;
        $display("[TB] FAIL %s underflow_cnt: got %0d, want %0d", name, ufCnt16, expCnt);
      end
    end
`endif
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bclk16, lrclk16, sd16, uf16, ready16} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset16 outputs: got %b, want 00001", {bclk16, lrclk16, sd16, uf16, ready16});
    end
    checks++;
    if ({bclk24, lrclk24, sd24, uf24, ready24} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset24 outputs: got %b, want 00001", {bclk24, lrclk24, sd24, uf24, ready24});
    end
    checkUf16(1'b0, 0, "reset");
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
  endtask

  task automatic test_i2s_frame();
    pushPair16(16'hA5F0, 16'h0F0F);
    @(negedge sclk);
    en16 = 1'b1;
    repeat (DIV - 1) @(posedge sclk);
    #1;
    checks++;
    if (bclk16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_rise_early: got %b, want 0", bclk16);
    end
    @(posedge sclk); #1;
    checks++;
    if (bclk16 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_rise: got %b, want 1", bclk16);
    end
    repeat (DIV) @(posedge sclk);
    #1;
    checkUf16(1'b0, 0, "frame0_start");
    nextL = 16'($urandom);
    nextR = 16'($urandom);
    fork
      pushPair16(nextL, nextR);
      captureFrame(1'b0, 1'b1, 32'hA5F0, 32'h0F0F, 1'b0, "i2s_a5f0");
    join
  endtask

  task automatic test_lj();
    logic [15:0] bL, bR;
    bL = nextL;
    bR = nextR;
    checkUf16(1'b0, 0, "frameB_start");
    nextL = 16'($urandom);
    nextR = 16'($urandom);
    fork
      pushPair16(nextL, nextR);
      begin #40 mode16 = I2S_MODE_LJ; end
      captureFrame(1'b0, 1'b1, {16'h0, bL}, {16'h0, bR}, 1'b0, "midframe_mode");
    join
    checkUf16(1'b0, 0, "frameC_start");
    captureFrame(1'b0, 1'b1, {16'h0, nextL}, {16'h0, nextR}, 1'b1, "lj");
  endtask

  task automatic test_underflow();
    checkUf16(1'b1, 1, "starved1");
    fork
      begin #40 mode16 = I2S_MODE_PHILIPS; end
      captureFrame(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "starved1");
    join
    checkUf16(1'b1, 2, "starved2");
    captureFrame(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "starved2");
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] expPair;
    int acc = 0;
    int accStart;
    bit run = 1'b1;
    checkUf16(1'b1, 3, "starved3");
    fork
      begin : driver
        bit wasReady;
        left16 = 16'($urandom);
        right16 = 16'($urandom);
        valid16 = 1'b1;
        while (run) begin
          wasReady = ready16;
          @(posedge sclk); #1;
          if (wasReady) begin
            q.push_back({left16, right16});
            acc++;
            left16 = 16'($urandom);
            right16 = 16'($urandom);
          end
        end
        valid16 = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          accStart = acc;
          if (k == 0) begin
            captureFrame(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "b2b_starved");
          end else begin
            checks++;
            if (ready16 !== 1'b1) begin
              errors++;
              $display("[TB] FAIL b2b_ready_at_start k=%0d: got %b, want 1", k, ready16);
            end
            checkUf16(1'b0, -1, "b2b_start");
            checks++;
            if (q.size() != 1) begin
              errors++;
              $display("[TB] FAIL b2b_queue k=%0d: got %0d pairs, want 1", k, q.size());
            end
            expPair = (q.size() != 0) ? q.pop_front() : 32'h0;
            captureFrame(1'b0, 1'b1, {16'h0, expPair[31:16]}, {16'h0, expPair[15:0]}, 1'b0, "b2b");
          end
          checks++;
          if (acc - accStart != 1) begin
            errors++;
            $display("[TB] FAIL b2b_accepts k=%0d: got %0d, want 1", k, acc - accStart);
          end
        end
        run = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [15:0] pL, pR, qL, qR, rL, rR;
    repeat ((16 + 8) * 2 * DIV) @(posedge sclk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bclk16, lrclk16, sd16, uf16, ready16} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL midreset outputs: got %b, want 00001", {bclk16, lrclk16, sd16, uf16, ready16});
    end
    checkUf16(1'b0, 0, "midreset");
    en16 = 1'b0;
    #2 rst_n = 1'b1;
    pL = 16'($urandom); pR = 16'($urandom);
    pushPair16(pL, pR);
    @(negedge sclk);
    en16 = 1'b1;
    repeat (2 * DIV) @(posedge sclk);
    #1;
    checkUf16(1'b0, 0, "post_reset_start");
    qL = 16'($urandom); qR = 16'($urandom);
    fork
      pushPair16(qL, qR);
      captureFrame(1'b0, 1'b1, {16'h0, pL}, {16'h0, pR}, 1'b0, "post_reset");
    join
    checkUf16(1'b0, 0, "frameQ_start");
    repeat ((16 + 3) * 2 * DIV) @(posedge sclk);
    @(negedge sclk);
    en16 = 1'b0;
    @(posedge sclk); #1;
    checks++;
    if ({bclk16, lrclk16, sd16, uf16, ready16} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL disable outputs: got %b, want 00001", {bclk16, lrclk16, sd16, uf16, ready16});
    end
    rL = 16'($urandom); rR = 16'($urandom);
    pushPair16(rL, rR);
    checks++;
    if (ready16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disabled_accept: got ready=%b, want 0", ready16);
    end
    @(negedge sclk);
    en16 = 1'b1;
    repeat (2 * DIV) @(posedge sclk);
    #1;
    checkUf16(1'b0, -1, "reenable_start");
    captureFrame(1'b0, 1'b1, {16'h0, rL}, {16'h0, rR}, 1'b0, "reenable");
  endtask

  task automatic test_wide();
    int n = 0;
    left24 = 24'h800001;
    right24 = 24'($urandom);
    valid24 = 1'b1;
    while (!ready24 && n < 1000) begin
      @(posedge sclk); #1;
      n++;
    end
    @(posedge sclk); #1;
    valid24 = 1'b0;
    @(negedge sclk);
    en24 = 1'b1;
    repeat (2 * DIV) @(posedge sclk);
    #1;
    checks++;
    if (uf24 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wide_start underflow: got %b, want 0", uf24);
    end
    captureFrame(1'b1, 1'b1, 32'h800001, {8'h0, right24}, 1'b0, "wide");
    checks++;
    if (uf24 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wide_starved underflow: got %b, want 1", uf24);
    end
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    checks++;
    if (ufCnt24 !== 16'd1) begin
      errors++;
      $display("[TB] FAIL wide underflow_cnt: got %0d, want 1", ufCnt24);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_i2s_frame();
    test_lj();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parametrised stereo I2S/left-justified serial transmitter. Accepts left/right sample pairs over a valid/ready handshake into a one-pair holding buffer, derives bit and word clocks from `sclk` by an integer divider, and serialises MSB-first into fixed-width slots. It sits between the synthesizer's sample generator and the external DAC pins. Successor to the fixed 16-bit, free-running serialiser: it adds configurable width, slot and divider, a selectable framing mode, backpressure and underflow reporting.

## Interface
- `DATA_W`, 16: sample width per channel; 1 ≤ DATA_W ≤ SLOT_W.
- `SLOT_W`, 16: `bclk` periods per channel slot; bits beyond DATA_W are sent as 0.
- `DIV`, 16: `sclk` cycles per `bclk` half-period; must be ≥ 1.
- `sclk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: when high, clocks run; when low, the serial side idles.
- `mode` in 1: 0 = I2S (one-bit data delay), 1 = left-justified; sampled at frame start.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: holding buffer empty.
- `s_left` in DATA_W: left sample, two's complement.
- `s_right` in DATA_W: right sample.
- `bclk` out 1: bit clock, period 2·DIV `sclk` cycles.
- `lrclk` out 1: word select; 0 = left, 1 = right.
- `sd` out 1: serial data.
- `underflow` out 1: one-`sclk` pulse when a frame starts with the buffer empty.

## Operation
- Divider counts 0..DIV-1 while `en`=1. At DIV-1 it wraps and toggles `bclk`. A high-to-low toggle is a fall event.
- Frame position `p` (width log2(2·SLOT_W)) advances on each fall event, modulo 2·SLOT_W. Reset value is 2·SLOT_W-1, so the first fall event starts frame 0.
- On a fall event where `p` wraps to 0:
  - The shift register loads {left slot, right slot}. Each slot is the sample MSB-aligned and zero-padded to SLOT_W.
  - The buffer is marked empty.
  - `mode` is latched into the mode register.
  - If the buffer was empty, zeros are loaded and `underflow` pulses.
- On every fall event, `sd` = stream bit `p` (bit 0 = left MSB).
- `lrclk` value on each fall event:
  - Left-justified: (p ≥ SLOT_W).
  - I2S: (((p+1) mod 2·SLOT_W) ≥ SLOT_W). `lrclk` leads the data by one `bclk`, so the MSB appears one bit after the word-select change.
- Handshake: a transfer occurs when `s_valid`=1 and `s_ready`=1; the buffer becomes full on the next cycle. `s_ready` = buffer empty.
- An accept and a frame-start load in the same cycle can only happen with the buffer empty. In that case the frame underflows and the newly accepted pair is kept for the next frame.
- `en`=0:
  - Divider, `p`, `bclk`, `lrclk`, `sd` and the shift register return to their reset values synchronously.
  - The buffer contents and handshake are unaffected.
  - `underflow` stays low.

## Timing
- Reset values:
  - `bclk`=0, `lrclk`=0, `sd`=0, `underflow`=0, `s_ready`=1.
  - Buffer empty, mode register = I2S, divider = 0, `p`=2·SLOT_W-1.
- `bclk`, `lrclk`, `sd` and `underflow` are registered. They change on the `sclk` edge that produces the fall event (zero added latency). `sd` and `lrclk` are stable across the following `bclk` rise.
- From `en` rising, the first `bclk` rise comes after DIV cycles. The first frame starts after 2·DIV cycles.
- Frame length is 4·SLOT_W·DIV `sclk` cycles.
- Reset asserted mid-frame: all outputs take reset values immediately and the buffered pair is discarded.
- A `mode` change mid-frame has no effect until the next frame start.

## Configuration
- `I2S_TX_UNDERFLOW_CNT_EN` defined:
  - Adds output `underflow_cnt` [15:0], a saturating count of `underflow` pulses.
  - Reset to 0; holds at 0xFFFF once reached.
- Not defined: the port and counter are absent. The `underflow` pulse is unchanged.

## Structure
- Package `i2s_pkg`:
  - Mode enum `I2S_MODE_PHILIPS`=0, `I2S_MODE_LJ`=1.
  - Default constants `I2S_DATA_W`=16, `I2S_SLOT_W`=16, `I2S_DIV`=16.
- Sub-module `i2s_clk_div` (parameter DIV; inputs `sclk`, `rst_n`, `en`): produces `bclk` and a one-cycle `fall` strobe.
- The top level holds the buffer, position counter, shift register and framing logic.

## Test plan
- DIV=2, SLOT_W=DATA_W=16, I2S; push L=0xA5F0, R=0x0F0F with `en` high.
  - `lrclk` low for 16 bits starting one `bclk` before the L MSB.
  - `sd` sequence is 1010010111110000 then 0000111100001111, sampled on `bclk` rises.
  - Frame is 128 `sclk` cycles.
- Same config, mode=LJ: the first L MSB coincides with the `lrclk` 1→0 edge.
- DATA_W=24, SLOT_W=32, L=0x800001: slot is the 24 data bits followed by 8 zeros; R is zero-padded the same way.
- No push after one frame:
  - Next frame is all zeros.
  - `underflow` pulses exactly once per starved frame.
  - `underflow_cnt` increments when the macro is defined.
- Hold `s_valid` high continuously: exactly one accept per frame; `s_ready` rises on the frame-start cycle.
- Assert `rst_n` low at mid-right-slot: outputs go to reset values asynchronously. After release with a pushed pair, the first full frame is correct.
